tile_line_renderer: RTL



---
 rtl/tile_line_renderer_if.sv | 43 ++++
 rtl/tile_line_renderer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/tile_line_renderer_if.sv
// Request/handshake, BRAM read ports and line-buffer write port of the tile line renderer.
// The renderer uses the slave modport; the line scheduler / memory side uses master.
interface tile_line_renderer_if #(
  parameter int unsigned LINE_PIXELS = 400,
  parameter int unsigned MAP_BITS    = 6,
  parameter int unsigned BPP         = 2,
  parameter int unsigned COLOR_WIDTH = 8
);
  localparam int unsigned CW = MAP_BITS + 3;
  localparam int unsigned XW = $clog2(LINE_PIXELS);
  localparam int unsigned GW = 11 + $clog2(BPP);
  localparam int unsigned PW = 8 + BPP;

  logic                   start;
  logic [CW-1:0]          line_y;
  logic                   bank;
  logic [CW-1:0]          scroll_x;
  logic [CW-1:0]          scroll_y;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic [2*MAP_BITS-1:0]  map_addr;
  logic [7:0]             map_data;
  logic [GW-1:0]          glyph_addr;
  logic [7:0]             glyph_data;
  logic [PW-1:0]          pal_addr;
  logic [COLOR_WIDTH-1:0] pal_data;
  logic                   lb_we;
  logic [XW:0]            lb_addr;
  logic [COLOR_WIDTH-1:0] lb_data;

  modport master (
    output start, line_y, bank, scroll_x, scroll_y, abort,
    output map_data, glyph_data, pal_data,
    input  busy, done, map_addr, glyph_addr, pal_addr, lb_we, lb_addr, lb_data
  );

  modport slave (
    input  start, line_y, bank, scroll_x, scroll_y, abort,
    input  map_data, glyph_data, pal_data,
    output busy, done, map_addr, glyph_addr, pal_addr, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/tile_line_renderer.sv
// Renders one scrolled tile-map scanline into a line-buffer bank through a
// 4-stage pipeline over three 1-cycle-latency BRAM read ports (map, glyph, palette).
module tile_line_renderer #(
  parameter int unsigned LINE_PIXELS = 400,
  parameter int unsigned MAP_BITS    = 6,
  parameter int unsigned BPP         = 2,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned TRANSP_EN   = 0
) (
  input logic clk,
  input logic rst_n,
  tile_line_renderer_if.slave bus
);
  localparam int unsigned CW     = MAP_BITS + 3;
  localparam int unsigned XW     = $clog2(LINE_PIXELS);
  localparam int unsigned PPB    = 8 / BPP;
  localparam int unsigned PPB_W  = $clog2(PPB);
  localparam int unsigned BYTE_W = $clog2(BPP);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic          bank_q;
  logic [XW-1:0] x_q;
  logic [CW-1:0] sx_q;
  logic [CW-1:0] sy_q;
  logic [1:0]    drain_q;

  logic          v2_q;
  logic [XW-1:0] x2_q;
  logic [2:0]    px2_q;
  logic          v3_q;
  logic [XW-1:0] x3_q;
  logic [2:0]    px3_q;
  logic [7:0]    tile3_q;
  logic          lb_we_q;
  logic [XW:0]   lb_addr_q;

  logic [2:0]     fld;
  logic [7:0]     glyph_shift;
  logic [BPP-1:0] pix_idx;
  logic           transp_hit;

  // Read addresses come straight from pipeline registers plus returned BRAM data.
  assign bus.map_addr   = {sy_q[CW-1:3], sx_q[CW-1:3]};
  assign bus.glyph_addr = {bus.map_data, sy_q[2:0], BYTE_W'(px2_q >> PPB_W)};

  // Field 0 of a glyph byte is the leftmost pixel, held in the MSBs.
  assign fld         = 3'(px3_q[PPB_W-1:0]);
  assign glyph_shift = bus.glyph_data << (3'(BPP) * fld);
  assign pix_idx     = glyph_shift[7 -: BPP];
  assign transp_hit  = (TRANSP_EN != 0) && (pix_idx == '0);
  assign bus.pal_addr = {tile3_q, pix_idx};

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.lb_we   = lb_we_q;
  assign bus.lb_addr = lb_addr_q;
  assign bus.lb_data = bus.pal_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bank_q    <= 1'b0;
      x_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      drain_q   <= '0;
      v2_q      <= 1'b0;
      x2_q      <= '0;
      px2_q     <= '0;
      v3_q      <= 1'b0;
      x3_q      <= '0;
      px3_q     <= '0;
      tile3_q   <= '0;
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
    end else begin
      // Pipeline advances every cycle; only stage 1 is gated by the FSM.
      v2_q      <= (state == RUN);
      x2_q      <= x_q;
      px2_q     <= sx_q[2:0];
      v3_q      <= v2_q;
      x3_q      <= x2_q;
      px3_q     <= px2_q;
      tile3_q   <= bus.map_data;
      lb_we_q   <= v3_q && !transp_hit;
      lb_addr_q <= {bank_q, x3_q};
      done_q    <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            bank_q  <= bus.bank;
            x_q     <= '0;
            sx_q    <= bus.scroll_x;
            sy_q    <= bus.line_y + bus.scroll_y;
          end
        end
        RUN: begin
          if (x_q == X_LAST) begin
            state   <= DRAIN;
            drain_q <= '0;
          end else begin
            x_q  <= x_q + XW'(1);
            sx_q <= sx_q + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_q == 2'd2) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort squashes everything still in flight, including the pending done.
      if (bus.abort && (state != IDLE)) begin
        state   <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        v2_q    <= 1'b0;
        v3_q    <= 1'b0;
        lb_we_q <= 1'b0;
      end
    end
  end
endmodule
